// File: rtl/puf_pkg.sv
// Shared types and defaults for the RO PUF measurement stage.
package puf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        MEASURE,
        COMPARE,
        DONE
    } state_t;

    localparam int unsigned DEF_CNT_W      = 16;
    localparam int unsigned DEF_WINDOW     = 1024;
    localparam int unsigned DEF_SETTLE_CYC = 8;

    // Width of the shared settle/window timer.
    function automatic int unsigned timer_width(input int unsigned window,
                                                input int unsigned settle);
        int unsigned longest;
        longest = (window > settle) ? window : settle;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronises one asynchronous RO output, detects rising edges and counts
// them into a saturating counter.
module ro_edge_counter
    import puf_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ro,
    input  logic             clr,
    input  logic             cnt_en,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    logic sync1;
    logic sync2;
    logic prev;
    logic rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= ro;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;
    assign sat  = (count == '1);

    // Counter is only cleared at measurement start, so sat reflects this run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (cnt_en && rise && !sat) begin
            count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/ro_puf_counter.sv
// RO pair measurement stage: gates the oscillators, counts edges over a fixed
// window and produces one PUF response bit.
module ro_puf_counter
    import puf_pkg::*;
#(
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned WINDOW     = DEF_WINDOW,
    parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ro_a,
    input  logic             ro_b,
    output logic             ro_en,
    output logic             busy,
    output logic             done,
    output logic             resp,
    output logic             tie,
    output logic             sat,
    output logic [CNT_W-1:0] count_a,
    output logic [CNT_W-1:0] count_b
);

    localparam int unsigned   TW          = timer_width(WINDOW, SETTLE_CYC);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] WINDOW_LAST = TW'(WINDOW - 1);

    state_t        state;
    state_t        nstate;
    logic [TW-1:0] timer;
    logic          accept;
    logic          cnt_en;
    logic          sat_a;
    logic          sat_b;

    assign accept = (state == IDLE) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (start) nstate = SETTLE;
            SETTLE:  if (timer == SETTLE_LAST) nstate = MEASURE;
            MEASURE: if (timer == WINDOW_LAST) nstate = COMPARE;
            COMPARE: nstate = DONE;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        ro_en  = 1'b0;
        busy   = 1'b1;
        done   = 1'b0;
        cnt_en = 1'b0;
        case (state)
            IDLE:    busy = 1'b0;
            SETTLE:  ro_en = 1'b1;
            MEASURE: begin
                ro_en  = 1'b1;
                cnt_en = 1'b1;
            end
            COMPARE: ro_en = 1'b0;
            DONE:    done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // One timer serves both phases; it restarts on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (state != nstate) begin
            timer <= '0;
        end else if (state == SETTLE || state == MEASURE) begin
            timer <= timer + {{(TW-1){1'b0}}, 1'b1};
        end
    end

    ro_edge_counter #(
        .CNT_W (CNT_W)
    ) u_cnt_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .ro     (ro_a),
        .clr    (accept),
        .cnt_en (cnt_en),
        .count  (count_a),
        .sat    (sat_a)
    );

    ro_edge_counter #(
        .CNT_W (CNT_W)
    ) u_cnt_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .ro     (ro_b),
        .clr    (accept),
        .cnt_en (cnt_en),
        .count  (count_b),
        .sat    (sat_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp <= 1'b0;
            tie  <= 1'b0;
            sat  <= 1'b0;
        end else if (accept) begin
            resp <= 1'b0;
            tie  <= 1'b0;
            sat  <= 1'b0;
        end else if (state == COMPARE) begin
            resp <= (count_a > count_b);
            tie  <= (count_a == count_b);
            sat  <= sat_a | sat_b;
        end
    end

endmodule

// File: tb/tb_ro_puf_counter.sv
// Directed scoreboard bench for ro_puf_counter (16-bit and 4-bit counter builds).
module tb_ro_puf_counter;

    localparam int WIN = 96;
    localparam int SET = 8;
    localparam int LAT = 1 + SET + WIN + 1;

    typedef struct {
        int lat;
        int a_lo;
        int a_hi;
        int b_lo;
        int b_hi;
        bit eq_ab;
        int resp;
        int tie;
        int sat;
    } exp_t;

    exp_t sbq[$];

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sel4;
    logic        ro_a_g;
    logic        ro_b_g;
    logic        ro_a4_g;
    logic        b_copy;
    logic        b_run;
    logic        zero_b4;
    int          half_a;
    int          half_b;

    logic        start16, start4, ro_b16;
    logic        ro_en16, busy16, done16, resp16, tie16, sat16;
    logic [15:0] cnt_a16, cnt_b16;
    logic        ro_en4, busy4, done4, resp4, tie4, sat4;
    logic [3:0]  cnt_a4, cnt_b4;

    logic        o_ro_en, o_busy, o_done, o_resp, o_tie, o_sat;
    logic [15:0] o_cnt_a, o_cnt_b;

    int n_assert;
    int n_fail;

    assign start16 = start & ~sel4;
    assign start4  = start & sel4;
    assign ro_b16  = b_copy ? ro_a_g : ro_b_g;

    assign o_ro_en = sel4 ? ro_en4 : ro_en16;
    assign o_busy  = sel4 ? busy4  : busy16;
    assign o_done  = sel4 ? done4  : done16;
    assign o_resp  = sel4 ? resp4  : resp16;
    assign o_tie   = sel4 ? tie4   : tie16;
    assign o_sat   = sel4 ? sat4   : sat16;
    assign o_cnt_a = sel4 ? {12'd0, cnt_a4} : cnt_a16;
    assign o_cnt_b = sel4 ? {12'd0, cnt_b4} : cnt_b16;

    ro_puf_counter #(
        .CNT_W      (16),
        .WINDOW     (WIN),
        .SETTLE_CYC (SET)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start16),
        .ro_a    (ro_a_g),
        .ro_b    (ro_b16),
        .ro_en   (ro_en16),
        .busy    (busy16),
        .done    (done16),
        .resp    (resp16),
        .tie     (tie16),
        .sat     (sat16),
        .count_a (cnt_a16),
        .count_b (cnt_b16)
    );

    ro_puf_counter #(
        .CNT_W      (4),
        .WINDOW     (WIN),
        .SETTLE_CYC (SET)
    ) dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start4),
        .ro_a    (ro_a4_g),
        .ro_b    (zero_b4),
        .ro_en   (ro_en4),
        .busy    (busy4),
        .done    (done4),
        .resp    (resp4),
        .tie     (tie4),
        .sat     (sat4),
        .count_a (cnt_a4),
        .count_b (cnt_b4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Oscillator models, offset so their edges never coincide with clk edges.
    initial begin
        ro_a_g = 1'b0;
        #3;
        forever begin
            #(half_a);
            ro_a_g = ~ro_a_g;
        end
    end

    initial begin
        ro_b_g = 1'b0;
        #4;
        forever begin
            #(half_b);
            ro_b_g = b_run ? ~ro_b_g : 1'b0;
        end
    end

    initial begin
        ro_a4_g = 1'b0;
        #2;
        forever begin
            #15;
            ro_a4_g = ~ro_a4_g;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int a_lo, input int a_hi, input int b_lo, input int b_hi,
                            input bit eq_ab, input int resp, input int tie, input int sat);
        exp_t e;
        e.lat   = LAT;
        e.a_lo  = a_lo;
        e.a_hi  = a_hi;
        e.b_lo  = b_lo;
        e.b_hi  = b_hi;
        e.eq_ab = eq_ab;
        e.resp  = resp;
        e.tie   = tie;
        e.sat   = sat;
        sbq.push_back(e);
    endtask

    // Runs one measurement; restart_at re-pulses start, rst_at aborts with reset.
    task automatic run(input string tag, input int restart_at, input int rst_at);
        exp_t e;
        int   n;
        int   extra;
        bit   seen;
        bit   busy_ok;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        seen    = 1'b0;
        busy_ok = 1'b1;
        for (n = 1; n <= 400; n++) begin
            @(negedge clk);
            start = (n == restart_at);
            if (n == rst_at) begin
                check({tag, "_ro_en_pre_rst"}, int'(o_ro_en), 1);
                rst_n = 1'b0;
                #1;
                check({tag, "_rst_ro_en"}, int'(o_ro_en), 0);
                check({tag, "_rst_busy"},  int'(o_busy), 0);
                check({tag, "_rst_done"},  int'(o_done), 0);
                check({tag, "_rst_cnt_a"}, int'(o_cnt_a), 0);
                check({tag, "_rst_cnt_b"}, int'(o_cnt_b), 0);
                void'(sbq.pop_front());
                start = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                repeat (3) @(negedge clk);
                return;
            end
            if (o_done) begin
                seen = 1'b1;
                break;
            end
            if (!o_busy) busy_ok = 1'b0;
        end
        start = 1'b0;
        e = sbq.pop_front();
        check({tag, "_done_seen"}, int'(seen), 1);
        if (!seen) return;
        check({tag, "_latency"},  n, e.lat);
        check({tag, "_busy_cont"}, int'(busy_ok), 1);
        check({tag, "_busy_at_done"}, int'(o_busy), 1);
        check({tag, "_cnt_a_range"}, int'(o_cnt_a >= e.a_lo && o_cnt_a <= e.a_hi), 1);
        check({tag, "_cnt_b_range"}, int'(o_cnt_b >= e.b_lo && o_cnt_b <= e.b_hi), 1);
        if (e.eq_ab) check({tag, "_cnt_eq"}, int'(o_cnt_a), int'(o_cnt_b));
        check({tag, "_resp"}, int'(o_resp), e.resp);
        check({tag, "_tie"},  int'(o_tie),  e.tie);
        check({tag, "_sat"},  int'(o_sat),  e.sat);
        @(negedge clk);
        check({tag, "_done_1cyc"}, int'(o_done), 0);
        check({tag, "_busy_drop"}, int'(o_busy), 0);
        check({tag, "_resp_hold"}, int'(o_resp), e.resp);
        extra = 0;
        repeat (150) begin
            @(negedge clk);
            if (o_done) extra++;
        end
        check({tag, "_no_extra_done"}, extra, 0);
    endtask

    initial begin
        int bad_en;
        int bad_done;
        int bad_cnt;
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        sel4     = 1'b0;
        b_copy   = 1'b0;
        b_run    = 1'b1;
        zero_b4  = 1'b0;
        half_a   = 20;
        half_b   = 30;

        #12;
        check("rst_ro_en", int'(ro_en16), 0);
        check("rst_busy",  int'(busy16), 0);
        check("rst_done",  int'(done16), 0);
        check("rst_resp",  int'(resp16), 0);
        check("rst_tie",   int'(tie16), 0);
        check("rst_sat",   int'(sat16), 0);
        check("rst_cnt_a", int'(cnt_a16), 0);
        check("rst_cnt_b", int'(cnt_b16), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Oscillators toggle freely while idle; nothing must happen.
        bad_en = 0;
        bad_done = 0;
        bad_cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (ro_en16 || ro_en4) bad_en++;
            if (done16 || done4) bad_done++;
            if (cnt_a16 != 0 || cnt_b16 != 0 || cnt_a4 != 0) bad_cnt++;
        end
        check("idle_ro_en", bad_en, 0);
        check("idle_done",  bad_done, 0);
        check("idle_cnt",   bad_cnt, 0);

        push_exp(23, 25, 15, 17, 1'b0, 1, 0, 0);
        run("a40_b60", 0, 0);

        b_copy = 1'b1;
        push_exp(23, 25, 23, 25, 1'b1, 0, 1, 0);
        run("inphase", 0, 0);
        b_copy = 1'b0;

        sel4 = 1'b1;
        push_exp(15, 15, 0, 0, 1'b0, 1, 0, 1);
        run("sat4", 0, 0);
        sel4 = 1'b0;

        push_exp(23, 25, 15, 17, 1'b0, 1, 0, 0);
        run("restart", 50, 0);

        push_exp(23, 25, 15, 17, 1'b0, 1, 0, 0);
        run("abort", 0, 50);

        push_exp(23, 25, 15, 17, 1'b0, 1, 0, 0);
        run("after_rst", 0, 0);

        check("sb_empty", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
